// File: rtl/i2c_sensor_if.sv
// Register-side bundle of the I2C sensor target: register file in, write strobes and status out.
interface i2c_sensor_if #(
    parameter int unsigned NUM_REGS = 8
);
    localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [8*NUM_REGS-1:0] reg_data;
    logic                  wr_valid;
    logic [PTR_W-1:0]      wr_addr;
    logic [7:0]            wr_data;
    logic                  busy;
    logic                  addr_hit;

    // The target consumes the register file and produces the strobes/status.
    modport slave (
        input  reg_data,
        output wr_valid, wr_addr, wr_data, busy, addr_hit
    );

    // The host side supplies the register file and observes the strobes/status.
    modport master (
        output reg_data,
        input  wr_valid, wr_addr, wr_data, busy, addr_hit
    );
endinterface

// File: rtl/i2c_sensor_target.sv
// I2C target at DEV_ADDR exposing NUM_REGS register bytes: pointer write, sequential
// snapshot reads, and data writes emitted as one-clk strobes. SCL is never stretched.
module i2c_sensor_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h68,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         SCL,
    inout  wire          SDA,
    i2c_sensor_if.slave  bus
);
    localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned REG_W = 8 * NUM_REGS;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_MACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   r_ev_rise;
    logic                   r_ev_fall;
    logic                   r_ev_start;
    logic                   r_ev_stop;
    logic                   r_sda_smp;

    logic w_scl_s;
    logic w_sda_s;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [7:0]         r_shift;
    logic               r_phase;
    logic               r_rw;
    logic [PTR_W-1:0]   r_ptr;
    logic [REG_W-1:0]   r_shadow;
    logic [7:0]         r_tx;
    logic               r_sda_oe;
    logic               r_wr_valid;
    logic [PTR_W-1:0]   r_wr_addr;
    logic [7:0]         r_wr_data;
    logic               r_busy;
    logic               r_addr_hit;

    state_t             w_state_nxt;
    logic [2:0]         w_cnt_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_phase_nxt;
    logic               w_rw_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [REG_W-1:0]   w_shadow_nxt;
    logic [7:0]         w_tx_nxt;
    logic               w_sda_oe_nxt;
    logic               w_wr_valid_nxt;
    logic [PTR_W-1:0]   w_wr_addr_nxt;
    logic [7:0]         w_wr_data_nxt;
    logic               w_busy_nxt;
    logic               w_hit_nxt;

    logic [7:0]         w_rx_byte;
    logic [7:0]         w_shadow_byte;

    // Open-drain pad: only ever pull low.
    assign SDA = r_sda_oe ? 1'b0 : 1'bz;

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl_s & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_s &  r_scl_prev;
    assign w_start    =  w_scl_s & r_scl_prev &  r_sda_prev & ~w_sda_s;
    assign w_stop     =  w_scl_s & r_scl_prev & ~r_sda_prev &  w_sda_s;

    assign w_rx_byte     = {r_shift[6:0], r_sda_smp};
    assign w_shadow_byte = r_shadow[{r_ptr, 3'b000} +: 8];

    // Synchronise the bus pins and register the decoded bus events.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_ev_rise  <= 1'b0;
            r_ev_fall  <= 1'b0;
            r_ev_start <= 1'b0;
            r_ev_stop  <= 1'b0;
            r_sda_smp  <= 1'b1;
        end else begin
            r_scl_sync <= (r_scl_sync << 1) | SYNC_STAGES'(SCL);
            r_sda_sync <= (r_sda_sync << 1) | SYNC_STAGES'(SDA);
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
            r_ev_rise  <= w_scl_rise;
            r_ev_fall  <= w_scl_fall;
            r_ev_start <= w_start;
            r_ev_stop  <= w_stop;
            r_sda_smp  <= w_sda_s;
        end
    end

    // Protocol state register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 8'd0;
            r_phase    <= 1'b0;
            r_rw       <= 1'b0;
            r_ptr      <= '0;
            r_shadow   <= '0;
            r_tx       <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
            r_busy     <= 1'b0;
            r_addr_hit <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_phase    <= w_phase_nxt;
            r_rw       <= w_rw_nxt;
            r_ptr      <= w_ptr_nxt;
            r_shadow   <= w_shadow_nxt;
            r_tx       <= w_tx_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_busy     <= w_busy_nxt;
            r_addr_hit <= w_hit_nxt;
        end
    end

    // Next-state logic: START/STOP override any SCL edge seen in the same clk.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_phase_nxt    = r_phase;
        w_rw_nxt       = r_rw;
        w_ptr_nxt      = r_ptr;
        w_shadow_nxt   = r_shadow;
        w_tx_nxt       = r_tx;
        w_sda_oe_nxt   = r_sda_oe;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_busy_nxt     = r_busy;
        w_hit_nxt      = r_addr_hit;

        if (r_ev_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_hit_nxt    = 1'b0;
        end else if (r_ev_start) begin
            w_state_nxt  = ST_ADDR;
            w_cnt_nxt    = 3'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b1;
            w_hit_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (r_ev_rise) begin
                        w_shift_nxt = w_rx_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rw_nxt    = w_rx_byte[0];
                            w_phase_nxt = 1'b0;
                            if (w_rx_byte[7:1] == DEV_ADDR) begin
                                w_state_nxt = ST_ADDR_ACK;
                                if (w_rx_byte[0]) begin
                                    w_shadow_nxt = bus.reg_data;
                                end
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (r_ev_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                            w_hit_nxt    = 1'b1;
                        end else begin
                            w_phase_nxt  = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_sda_oe_nxt = 1'b0;
                            if (r_rw) begin
                                w_state_nxt  = ST_RDATA;
                                w_tx_nxt     = w_shadow_byte;
                                w_sda_oe_nxt = ~w_shadow_byte[7];
                            end else begin
                                w_state_nxt = ST_PTR;
                            end
                        end
                    end
                end

                ST_PTR, ST_WDATA: begin
                    if (r_ev_rise) begin
                        w_shift_nxt = w_rx_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_phase_nxt = 1'b0;
                            if (r_state == ST_PTR) begin
                                w_ptr_nxt   = PTR_W'(w_rx_byte);
                                w_state_nxt = ST_PTR_ACK;
                            end else begin
                                w_wr_valid_nxt = 1'b1;
                                w_wr_addr_nxt  = r_ptr;
                                w_wr_data_nxt  = w_rx_byte;
                                w_ptr_nxt      = r_ptr + PTR_W'(1);
                                w_state_nxt    = ST_WDATA_ACK;
                            end
                        end
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (r_ev_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt = 1'b1;
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_phase_nxt  = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_state_nxt  = ST_WDATA;
                        end
                    end
                end

                ST_RDATA: begin
                    if (r_ev_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_phase_nxt  = 1'b0;
                            w_state_nxt  = ST_RD_MACK;
                        end else begin
                            w_sda_oe_nxt = ~r_tx[6];
                            w_tx_nxt     = {r_tx[6:0], 1'b0};
                            w_cnt_nxt    = r_cnt + 3'd1;
                        end
                    end
                end

                ST_RD_MACK: begin
                    if (!r_phase) begin
                        if (r_ev_rise) begin
                            if (!r_sda_smp) begin
                                w_ptr_nxt   = r_ptr + PTR_W'(1);
                                w_phase_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end
                    end else if (r_ev_fall) begin
                        w_phase_nxt  = 1'b0;
                        w_cnt_nxt    = 3'd0;
                        w_tx_nxt     = w_shadow_byte;
                        w_sda_oe_nxt = ~w_shadow_byte[7];
                        w_state_nxt  = ST_RDATA;
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.addr_hit = r_addr_hit;
endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bench for i2c_sensor_target: bit-banged I2C master, array/queue model of the register
// pointer, snapshot and write strobes, plus literal expectations for the directed cases.
module tb_i2c_sensor_target;
    localparam int unsigned NREG = 8;
    localparam int          Q    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic scl_m;
    logic sda_m_low;
    wire  sda_bus;

    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_sensor_if #(.NUM_REGS(NREG)) bus ();

    i2c_sensor_target #(
        .DEV_ADDR   (7'h68),
        .NUM_REGS   (NREG),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .SCL   (scl_m),
        .SDA   (sda_bus),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Model state: register file, read snapshot, pointer, expected write strobes.
    logic [7:0] regs [NREG];
    logic [7:0] snap [NREG];
    int         mdl_ptr = 0;
    int         q_addr[$];
    int         q_data[$];
    int         dut_low_cnt = 0;

    task automatic set_regs(input int base);
        for (int i = 0; i < int'(NREG); i++) begin
            regs[i] = 8'(base + i);
            bus.reg_data[8*i +: 8] = regs[i];
        end
    endtask

    task automatic mdl_snap();
        for (int i = 0; i < int'(NREG); i++) snap[i] = regs[i];
    endtask

    task automatic mdl_set_ptr(input int p);
        mdl_ptr = p % int'(NREG);
    endtask

    task automatic mdl_wr(input int d);
        q_addr.push_back(mdl_ptr);
        q_data.push_back(d);
        mdl_ptr = (mdl_ptr + 1) % int'(NREG);
    endtask

    task automatic mdl_rd(input bit ack, output logic [7:0] e);
        e = snap[mdl_ptr];
        if (ack) mdl_ptr = (mdl_ptr + 1) % int'(NREG);
    endtask

    // Every write strobe must match the next expected (addr, data) from the model.
    always @(negedge clk) begin
        if (rst_n && bus.wr_valid) begin
            chk("wr_strobe_expected", int'(q_addr.size() > 0), 1);
            if (q_addr.size() > 0) begin
                chk("wr_addr", int'(bus.wr_addr), q_addr.pop_front());
                chk("wr_data", int'(bus.wr_data), q_data.pop_front());
            end
        end
    end

    // Count clks where the target pulls SDA low.
    always @(negedge clk) begin
        if (sda_bus === 1'b0 && !sda_m_low) dut_low_cnt++;
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        sda_m_low = 1'b0; wq(Q);
        scl_m = 1'b1;     wq(Q);
        sda_m_low = 1'b1; wq(Q);
        scl_m = 1'b0;     wq(Q);
    endtask

    task automatic m_stop();
        scl_m = 1'b0;     wq(Q);
        sda_m_low = 1'b1; wq(Q);
        scl_m = 1'b1;     wq(Q);
        sda_m_low = 1'b0; wq(2*Q);
    endtask

    task automatic m_bit(input logic b, output logic s);
        sda_m_low = ~b; wq(Q);
        scl_m = 1'b1;   wq(Q);
        s = sda_bus;    wq(Q);
        scl_m = 1'b0;   wq(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack_n);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(d[i], s);
        m_bit(1'b1, ack_n);
    endtask

    task automatic m_rbyte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(~mack, s);
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] lit2 [4];
        lit2 = '{8'h16, 8'h17, 8'h10, 8'h11};

        rst_n = 1'b0; scl_m = 1'b1; sda_m_low = 1'b0;
        set_regs(0);
        wq(5);
        chk("rst_sda", int'(sda_bus), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_hit", int'(bus.addr_hit), 0);
        chk("rst_wr_valid", int'(bus.wr_valid), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        rst_n = 1'b1;
        wq(5);

        // 1: pointer 2, two data bytes
        set_regs(8'h10);
        m_start();
        m_wbyte(8'hD0, a); chk("t1_ack_addr", int'(a), 0);
        chk("t1_busy", int'(bus.busy), 1);
        chk("t1_hit", int'(bus.addr_hit), 1);
        mdl_set_ptr(8'h02);
        m_wbyte(8'h02, a); chk("t1_ack_ptr", int'(a), 0);
        mdl_wr(8'hA5);
        m_wbyte(8'hA5, a); chk("t1_ack_d0", int'(a), 0);
        mdl_wr(8'h5A);
        m_wbyte(8'h5A, a); chk("t1_ack_d1", int'(a), 0);
        m_stop();
        chk("t1_busy_stop", int'(bus.busy), 0);
        chk("t1_hit_stop", int'(bus.addr_hit), 0);
        chk("t1_last_addr", int'(bus.wr_addr), 3);
        chk("t1_last_data", int'(bus.wr_data), 8'h5A);
        chk("t1_strobes_left", q_addr.size(), 0);

        // 2: pointer 6, repeated START, 4-byte read wrapping
        m_start();
        m_wbyte(8'hD0, a); chk("t2_ack_addr", int'(a), 0);
        mdl_set_ptr(8'h06);
        m_wbyte(8'h06, a); chk("t2_ack_ptr", int'(a), 0);
        m_start();
        mdl_snap();
        m_wbyte(8'hD1, a); chk("t2_ack_raddr", int'(a), 0);
        for (int i = 0; i < 4; i++) begin
            mdl_rd(i < 3, e);
            m_rbyte(i < 3, d);
            chk($sformatf("t2_rd%0d_model", i), int'(d), int'(e));
            chk($sformatf("t2_rd%0d_lit", i), int'(d), int'(lit2[i]));
        end
        m_stop();

        // 3: foreign address is never acknowledged
        dut_low_cnt = 0;
        m_start();
        m_wbyte(8'hA0, a); chk("t3_nack_addr", int'(a), 1);
        chk("t3_busy", int'(bus.busy), 1);
        chk("t3_hit", int'(bus.addr_hit), 0);
        m_wbyte(8'h3C, a); chk("t3_nack_byte", int'(a), 1);
        chk("t3_busy_late", int'(bus.busy), 1);
        m_stop();
        chk("t3_sda_never_driven", dut_low_cnt, 0);
        chk("t3_busy_stop", int'(bus.busy), 0);

        // 4: register change mid-burst does not affect returned bytes
        m_start();
        mdl_snap();
        m_wbyte(8'hD1, a); chk("t4_ack_addr", int'(a), 0);
        mdl_rd(1'b1, e); m_rbyte(1'b1, d); chk("t4_rd0", int'(d), int'(e));
        set_regs(8'hE0);
        mdl_rd(1'b1, e); m_rbyte(1'b1, d); chk("t4_rd1", int'(d), int'(e));
        chk("t4_rd1_lit", int'(d), 8'h12);
        mdl_rd(1'b0, e); m_rbyte(1'b0, d); chk("t4_rd2", int'(d), int'(e));
        m_stop();

        // 5: reset during the 5th bit of a read byte
        m_start();
        mdl_snap();
        m_wbyte(8'hD1, a); chk("t5_ack_addr", int'(a), 0);
        e = snap[mdl_ptr];
        for (int i = 7; i >= 4; i--) begin
            m_bit(1'b1, s);
            chk($sformatf("t5_bit%0d", i), int'(s), int'(e[i]));
        end
        sda_m_low = 1'b0; wq(Q);
        scl_m = 1'b1;     wq(Q);
        chk("t5_bit3_driven", int'(sda_bus), int'(e[3]));
        rst_n = 1'b0;
        wq(1);
        chk("t5_sda_released", int'(sda_bus), 1);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_hit", int'(bus.addr_hit), 0);
        chk("t5_wr_valid", int'(bus.wr_valid), 0);
        chk("t5_wr_addr", int'(bus.wr_addr), 0);
        chk("t5_wr_data", int'(bus.wr_data), 0);
        wq(4);
        rst_n = 1'b1;
        mdl_ptr = 0;
        wq(4);
        m_stop();
        m_start();
        m_wbyte(8'hD0, a); chk("t5_new_ack_addr", int'(a), 0);
        mdl_set_ptr(8'h04);
        m_wbyte(8'h04, a); chk("t5_new_ack_ptr", int'(a), 0);
        mdl_wr(8'h77);
        m_wbyte(8'h77, a); chk("t5_new_ack_data", int'(a), 0);
        m_stop();
        chk("t5_new_wr_addr", int'(bus.wr_addr), 4);
        chk("t5_new_wr_data", int'(bus.wr_data), 8'h77);

        // 6: STOP mid data byte, then read from the retained pointer (0x0E wraps to 6)
        m_start();
        m_wbyte(8'hD0, a); chk("t6_ack_addr", int'(a), 0);
        mdl_set_ptr(8'h0E);
        m_wbyte(8'h0E, a); chk("t6_ack_ptr", int'(a), 0);
        for (int i = 0; i < 3; i++) m_bit(1'b1, s);
        m_stop();
        chk("t6_busy_stop", int'(bus.busy), 0);
        m_start();
        mdl_snap();
        m_wbyte(8'hD1, a); chk("t6_ack_raddr", int'(a), 0);
        mdl_rd(1'b0, e); m_rbyte(1'b0, d);
        chk("t6_rd_model", int'(d), int'(e));
        chk("t6_rd_lit", int'(d), 8'hE6);
        m_stop();

        wq(20);
        chk("wr_strobes_left", q_addr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
